// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver: FSM encoding and the
// JK excitation table used to steer a flip-flop from its present Q to a target.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        APPLY = 2'd2,
        CHECK = 2'd3
    } jk_state_e;

    // Excitation table: returns {J,K} that moves Q to t; dc fills don't-care slots.
    function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic dc);
        logic [1:0] jk;
        case ({q, t})
            2'b00:   jk = {1'b0, dc};
            2'b01:   jk = {1'b1, dc};
            2'b10:   jk = {dc, 1'b1};
            default: jk = {dc, 1'b0};
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_bit_fifo.sv
// 1-bit wide circular FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module jk_bit_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic wr_bit,
    input  logic pop,
    output logic rd_bit,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_bit = mem[rd_ptr[AW-1:0]];

    // Pointer advance; writes into a full FIFO and reads from an empty one are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage holds data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_bit;
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK flip-flop so it follows a queued stream of
// target Q bits, then reads Q/QBAR back and flags any bit that was missed.
// One bit takes three cycles: LOAD (compute J/K), APPLY (FF samples), CHECK.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int   DEPTH   = 4,
    parameter logic DC_FILL = 1'b0,
    parameter int   CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             q_fb,
    input  logic             qbar_fb,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    jk_state_e  state;
    logic       tgt;
    logic       head_bit;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_en;
    logic       pop_en;
    logic       check_pass;
    logic [1:0] load_jk;

    // Saturating increment for the error counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign push_en    = in_valid && !fifo_full;
    assign pop_en     = (state == LOAD);
    assign in_ready   = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign check_pass = (q_fb == tgt) && (qbar_fb == ~q_fb);

    jk_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push_en),
        .wr_bit (in_bit),
        .pop    (pop_en),
        .rd_bit (head_bit),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Excitation for the head bit; an invalid Q/QBAR pair forces explicit set/reset.
    always_comb begin
        load_jk = jk_excite(q_fb, head_bit, DC_FILL);
        if (q_fb == qbar_fb) load_jk = {head_bit, ~head_bit};
    end

    // Target bit latched when it leaves the FIFO; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (state == LOAD) tgt <= head_bit;
    end

    // Sequencer with registered J/K, done and err outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            j         <= 1'b0;
            k         <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    j <= 1'b0;
                    k <= 1'b0;
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    {j, k} <= load_jk;
                    state  <= APPLY;
                end
                APPLY: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (!check_pass) begin
                        err       <= 1'b1;
                        err_count <= sat_inc(err_count);
                    end
                    j <= 1'b0;
                    k <= 1'b0;
                    // A bit arriving on this very edge keeps the stream going.
                    if (!fifo_empty || push_en) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (DC_FILL=0/CNT_W=8 and
// DC_FILL=1/CNT_W=2) share the input stream; each drives its own JK FF model.
module tb_jk_excitation_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic stuck = 1'b0;
    logic force_mode = 1'b0;

    logic       in_ready0, in_ready1, j0, k0, j1, k1;
    logic       busy0, busy1, done0, done1, err0, err1;
    logic [7:0] err_count0;
    logic [1:0] err_count1;
    logic       q0m, q1m;
    logic [1:0] prev0, prev1;
    logic       q_fb0, qbar_fb0, q_fb1, qbar_fb1, force_now;

    int cyc = 0;
    int t0 = 0;
    int mon_n = 0;
    logic mon_on = 1'b0;
    logic [1:0] exp0 [8];
    logic [1:0] exp1 [8];
    int err_seen0 = 0, err_seen1 = 0, done_seen0 = 0, done_seen1 = 0, jk_seen = 0;
    int stalls = 0;
    int n_cmp = 0, n_bad = 0;
    int b_e0, b_e1, b_d0, b_d1, b_jk;

    jk_excitation_driver #(.DEPTH(4), .DC_FILL(1'b0), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready0),
        .q_fb(q_fb0), .qbar_fb(qbar_fb0), .j(j0), .k(k0), .busy(busy0),
        .done(done0), .err(err0), .err_count(err_count0)
    );

    jk_excitation_driver #(.DEPTH(4), .DC_FILL(1'b1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready1),
        .q_fb(q_fb1), .qbar_fb(qbar_fb1), .j(j1), .k(k1), .busy(busy1),
        .done(done1), .err(err1), .err_count(err_count1)
    );

    // Feedback is forced to the invalid pair Q=QBAR=1 during LOAD cycles when requested.
    assign force_now = force_mode && mon_on && (cyc > t0) && (((cyc - t0 - 1) % 3) == 0);
    assign q_fb0    = force_now ? 1'b1 : q0m;
    assign qbar_fb0 = force_now ? 1'b1 : ~q0m;
    assign q_fb1    = force_now ? 1'b1 : q1m;
    assign qbar_fb1 = force_now ? 1'b1 : ~q1m;

    always @(posedge clk) cyc <= cyc + 1;

    // JK FF models, clocked once per excitation (first edge after J/K leave 00),
    // so a toggle code acts exactly once; stuck holds Q at 0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0m <= 1'b0; prev0 <= 2'b00;
            q1m <= 1'b0; prev1 <= 2'b00;
        end else begin
            prev0 <= {j0, k0};
            prev1 <= {j1, k1};
            if (!stuck && {j0, k0} != 2'b00 && prev0 == 2'b00)
                q0m <= ({j0, k0} == 2'b10) ? 1'b1 : ({j0, k0} == 2'b01) ? 1'b0 : ~q0m;
            if (!stuck && {j1, k1} != 2'b00 && prev1 == 2'b00)
                q1m <= ({j1, k1} == 2'b10) ? 1'b1 : ({j1, k1} == 2'b01) ? 1'b0 : ~q1m;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse counting, J/K check at the end of each LOAD, done timing.
    always @(negedge clk) begin : mon
        int idx;
        if (!rst) begin
            if (err0) err_seen0++;
            if (err1) err_seen1++;
            if (done0) begin
                done_seen0++;
                if (mon_on) chk("done_time0", 32'(cyc), 32'(t0 + 3 * mon_n + 1));
            end
            if (done1) begin
                done_seen1++;
                if (mon_on) chk("done_time1", 32'(cyc), 32'(t0 + 3 * mon_n + 1));
            end
            if (mon_on && cyc >= t0 + 2 && ((cyc - t0 - 2) % 3) == 0) begin
                idx = (cyc - t0 - 2) / 3;
                if (idx < mon_n) begin
                    chk($sformatf("jk0[%0d]", idx), 32'({j0, k0}), 32'(exp0[idx]));
                    chk($sformatf("jk1[%0d]", idx), 32'({j1, k1}), 32'(exp1[idx]));
                    jk_seen++;
                end
            end
        end
    end

    task automatic snap();
        b_e0 = err_seen0; b_e1 = err_seen1; b_d0 = done_seen0; b_d1 = done_seen1; b_jk = jk_seen;
    endtask

    // Called at a negedge; offers bits[0..n-1] in order, honouring in_ready.
    task automatic push_stream(input logic [7:0] bits, input int n);
        logic acc;
        int guard;
        snap();
        mon_on = 1'b0;
        mon_n  = n;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            acc      = 1'b0;
            guard    = 0;
            while (!acc && guard < 50) begin
                acc = in_ready0;
                @(negedge clk);
                if (!acc) stalls++;
                guard++;
            end
            if (!acc) chk("push_timeout", 32'(0), 32'(1));
            if (i == 0) begin
                t0     = cyc;
                mon_on = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_stream();
        while (cyc < t0 + 3 * mon_n + 3) @(negedge clk);
        mon_on = 1'b0;
    endtask

    task automatic end_checks(input string nm, input int e0, input int e1, input logic fq0, input logic fq1);
        chk({nm, "_err0"},  32'(err_seen0 - b_e0), 32'(e0));
        chk({nm, "_err1"},  32'(err_seen1 - b_e1), 32'(e1));
        chk({nm, "_done0"}, 32'(done_seen0 - b_d0), 32'(1));
        chk({nm, "_done1"}, 32'(done_seen1 - b_d1), 32'(1));
        chk({nm, "_jkcnt"}, 32'(jk_seen - b_jk), 32'(mon_n));
        chk({nm, "_q0"},    32'(q0m), 32'(fq0));
        chk({nm, "_q1"},    32'(q1m), 32'(fq1));
        chk({nm, "_busy0"}, 32'(busy0), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_j0", 32'(j0), 32'(0));
        chk("rst_k0", 32'(k0), 32'(0));
        chk("rst_j1", 32'(j1), 32'(0));
        chk("rst_k1", 32'(k1), 32'(0));
        chk("rst_err0", 32'(err0), 32'(0));
        chk("rst_done0", 32'(done0), 32'(0));
        chk("rst_cnt0", 32'(err_count0), 32'(0));
        chk("rst_cnt1", 32'(err_count1), 32'(0));
        chk("rst_ready0", 32'(in_ready0), 32'(1));
        chk("rst_busy0", 32'(busy0), 32'(0));
        chk("rst_busy1", 32'(busy1), 32'(0));

        // Stream 1,0,0,1 from Q=0 with a correct FF.
        exp0 = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        exp1 = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        push_stream(8'b0000_1001, 4);
        finish_stream();
        end_checks("basic", 0, 0, 1'b1, 1'b1);
        chk("basic_cnt0", 32'(err_count0), 32'(0));

        // FF stuck at 0: 1,1,1 then 1,1 more; 2-bit counter saturates at 3.
        do_reset();
        stuck = 1'b1;
        exp0 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        exp1 = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        push_stream(8'b0000_0111, 3);
        finish_stream();
        end_checks("stuck3", 3, 3, 1'b0, 1'b0);
        chk("stuck3_cnt0", 32'(err_count0), 32'(3));
        chk("stuck3_cnt1", 32'(err_count1), 32'(3));
        push_stream(8'b0000_0011, 2);
        finish_stream();
        end_checks("stuck5", 2, 2, 1'b0, 1'b0);
        chk("stuck5_cnt0", 32'(err_count0), 32'(5));
        chk("stuck5_cnt1", 32'(err_count1), 32'(3));
        stuck = 1'b0;

        // Q=QBAR=1 during LOAD: targets 0 then 1 must use explicit reset/set.
        do_reset();
        force_mode = 1'b1;
        exp0 = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        exp1 = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        push_stream(8'b0000_0010, 2);
        finish_stream();
        force_mode = 1'b0;
        end_checks("inval", 0, 0, 1'b1, 1'b1);

        // Six bits back-to-back into a 4-deep FIFO: one stall, order preserved.
        do_reset();
        exp0 = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
        exp1 = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
        push_stream(8'b0000_1011, 6);
        chk("six_stalls", 32'(stalls), 32'(1));
        finish_stream();
        end_checks("six", 0, 0, 1'b0, 1'b0);

        // Reset during APPLY of bit 2 of 4 (first bit fails while stuck).
        do_reset();
        stuck = 1'b1;
        exp0 = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        exp1 = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        push_stream(8'b0000_1101, 4);
        mon_n = 1;
        while (cyc < t0 + 5) @(negedge clk);
        chk("abort_err0", 32'(err_seen0 - b_e0), 32'(1));
        chk("abort_cnt0_pre", 32'(err_count0), 32'(1));
        rst = 1'b1;
        mon_on = 1'b0;
        #1;
        chk("abort_j0", 32'(j0), 32'(0));
        chk("abort_k0", 32'(k0), 32'(0));
        chk("abort_j1k1", 32'({j1, k1}), 32'(0));
        chk("abort_ready0", 32'(in_ready0), 32'(1));
        chk("abort_busy0", 32'(busy0), 32'(0));
        chk("abort_cnt0", 32'(err_count0), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        stuck = 1'b0;
        snap();
        repeat (8) @(negedge clk);
        chk("abort_noerr", 32'(err_seen0 - b_e0), 32'(0));
        chk("abort_nodone", 32'(done_seen0 - b_d0), 32'(0));
        chk("abort_idle", 32'(busy0), 32'(0));
        exp0 = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        exp1 = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        push_stream(8'b0000_0001, 1);
        finish_stream();
        end_checks("after", 0, 0, 1'b1, 1'b1);
        chk("after_cnt0", 32'(err_count0), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Transmit-side companion to the JK flip-flop: accepts a stream of target Q bits and drives J/K so that an external JK FF follows that sequence.
- Reads the FF's Q/QBAR back and flags any bit the FF failed to reach.
- Used as a stimulus generator and self-check in front of jkffstr-class flip-flops, in benches and on-chip test paths.

Parameters:
- DEPTH, 4, entries in the target-bit FIFO; power of two, >= 2
- DC_FILL, 0, value driven on J or K where the excitation table gives "don't care"
- CNT_W, 8, width of the saturating error counter

Ports:
- clk  input  1  rising-edge clock shared with the driven JK FF
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  target bit offered
- in_bit  input  1  target next-state value for Q
- in_ready  output  1  FIFO can accept a bit (not full)
- q_fb  input  1  Q from the driven FF
- qbar_fb  input  1  QBAR from the driven FF
- j  output  1  registered J to the FF
- k  output  1  registered K to the FF
- busy  output  1  FSM not in IDLE, or FIFO not empty
- done  output  1  one-cycle pulse when the last queued bit has been checked
- err  output  1  one-cycle pulse on a failed check
- err_count  output  CNT_W  saturating count of failed checks

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: j=0, k=0, err=0, done=0, err_count=0, FIFO empty, in_ready=1, busy=0, FSM=IDLE.
- Reset mid-operation flushes the FIFO and abandons the in-flight bit; no err or done pulse is produced.
- Push: a bit is written when in_valid && in_ready at a rising clk edge.
- in_ready = !full. A pop in the same cycle does not raise in_ready until the next cycle (no bypass).
- When full, in_valid is ignored; no data is lost because ready is low.
- FIFO is a circular buffer with wrap-around pointers plus one extra bit for full/empty.
- FSM states: IDLE, LOAD, APPLY, CHECK.
- IDLE: j=k=0, so the FF holds. Go to LOAD when the FIFO is not empty.
- LOAD (1 cycle): pop the head bit into tgt. Compute j/k from q_fb and tgt, registered at the end of the cycle:
  - q=0, t=0: J=0, K=DC_FILL
  - q=0, t=1: J=1, K=DC_FILL
  - q=1, t=0: J=DC_FILL, K=1
  - q=1, t=1: J=DC_FILL, K=0
  - If q_fb == qbar_fb (FF state invalid or unknown): force J=tgt, K=~tgt (explicit set/reset).
  - Go to APPLY.
- APPLY (1 cycle): j/k held stable across the edge where the FF samples them. Go to CHECK.
- CHECK (1 cycle): pass if q_fb == tgt and qbar_fb == ~q_fb.
  - On failure: err pulses for 1 cycle and err_count increments, saturating at 2^CNT_W-1.
  - j/k return to 0 at the end of CHECK.
  - Next state is LOAD if the FIFO is not empty; otherwise IDLE with a done pulse.
- Throughput: 3 cycles per bit. Latency from the push edge to the first j/k change is 2 edges when idle.
- A bit pushed during CHECK of the previous last bit continues to LOAD with no done pulse.
- err and done may pulse in the same cycle.
- j/k come straight from flops: glitch-free, no combinational path from q_fb to j/k.

Decomposition:
- Shared package jk_pkg holds:
  - FSM state encoding: IDLE=2'd0, LOAD=2'd1, APPLY=2'd2, CHECK=2'd3
  - excitation function jk_excite(q, t, dc), returning {J,K}; reused by the bench scoreboard
- One sub-module: jk_bit_fifo (DEPTH, 1-bit wide, push/pop/full/empty).

Test Plan:
- Reset then push 1,0,0,1 with q_fb from a correct FF model starting at Q=0 -> J/K sequence (1,0),(0,1),(0,0),(1,0) with DC_FILL=0; err never pulses; err_count=0; one done pulse 3 cycles after the last LOAD.
- Same stream with DC_FILL=1 -> J/K (1,1),(1,1),(0,1),(1,1); FF still reaches 1,0,0,1; err_count=0.
- FF model stuck at Q=0, push 1,1,1 -> err pulses 3 times; err_count=3. CNT_W=2 with 5 failures -> err_count saturates at 3.
- Hold q_fb=qbar_fb=1 at LOAD with target 0 -> J=0, K=1. Then a correct FF gives Q=0 at CHECK and no err.
- Push 6 bits back-to-back with DEPTH=4 -> in_ready drops after the 4th push (or the 5th if a pop coincides); all 6 bits are applied in order; no bit is lost or duplicated.
- Assert rst during APPLY of bit 2 of 4 -> j=k=0 and FIFO empty at once; no err or done pulse; the next stream after reset starts clean with err_count=0.
